// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between an I-cache (fills only)
// and a D-cache (fills and writebacks). A granted request is latched and the
// memory command is held until pmem_resp. The requester then sees a one-cycle
// completion pulse, with read data taken from an internal line buffer.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a conflict
// goes to the requester that was not served last. When it is undefined, the
// D-cache always wins a conflict.
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic              i_resp_q;
    logic              d_resp_q;
    logic              d_pend_s;
    logic              pick_d_s;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the D-cache owns the next conflict (the I-cache was served last).
    logic              prio_d_q;
`endif

    assign d_pend_s = d_read | d_write;

    // Decide which requester IDLE would grant on this edge.
    always_comb begin
        pick_d_s = 1'b0;
        if (d_pend_s && !i_read) begin
            pick_d_s = 1'b1;
        end else if (d_pend_s && i_read) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_d_s = prio_d_q;
`else
            pick_d_s = 1'b1;
`endif
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Transaction FSM with registered memory command and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    if (pick_d_s) begin
                        // A simultaneous read and write is treated as a writeback.
                        state_q      <= SERVE_D;
                        addr_q       <= d_address;
                        wdata_q      <= d_wdata;
                        pmem_write_q <= d_write;
                        pmem_read_q  <= ~d_write;
                    end else if (i_read) begin
                        state_q      <= SERVE_I;
                        addr_q       <= i_address;
                        pmem_read_q  <= 1'b1;
                        pmem_write_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        line_q      <= pmem_rdata;
                        pmem_read_q <= 1'b0;
                        i_resp_q    <= 1'b1;
                        state_q     <= DONE_I;
`ifdef ARB_ROUND_ROBIN_EN
                        prio_d_q    <= 1'b1;
`endif
                    end else begin
                        state_q <= SERVE_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        if (!pmem_write_q) begin
                            line_q <= pmem_rdata;
                        end else begin
                            line_q <= line_q;
                        end
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        d_resp_q     <= 1'b1;
                        state_q      <= DONE_D;
`ifdef ARB_ROUND_ROBIN_EN
                        prio_d_q     <= 1'b0;
`endif
                    end else begin
                        state_q <= SERVE_D;
                    end
                end
                DONE_I: begin
                    i_resp_q <= 1'b0;
                    state_q  <= IDLE;
                end
                DONE_D: begin
                    d_resp_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                    i_resp_q     <= 1'b0;
                    d_resp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;
    assign i_rdata      = line_q;
    assign d_rdata      = line_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256: cache-line width in bits on all line data ports.
REQ-002 Parameter ADDR_W, default 32: byte-address width on all address ports.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_read  input  1  I-cache line-fill request; held until i_resp.
REQ-006 i_address  input  ADDR_W  I-cache line address, line-aligned.
REQ-007 i_rdata  output  LINE_W  fill data to I-cache; valid while i_resp=1.
REQ-008 i_resp  output  1  one-cycle completion pulse to I-cache.
REQ-009 d_read / d_write  input  1 each  D-cache fill / writeback request; held until d_resp.
REQ-010 d_address  input  ADDR_W  D-cache line address, line-aligned.
REQ-011 d_wdata  input  LINE_W  writeback line data.
REQ-012 d_rdata  output  LINE_W  fill data to D-cache; valid while d_resp=1.
REQ-013 d_resp  output  1  one-cycle completion pulse to D-cache.
REQ-014 pmem_read / pmem_write  output  1 each  physical-memory command, held until pmem_resp.
REQ-015 pmem_address  output  ADDR_W  latched address of the granted request.
REQ-016 pmem_wdata  output  LINE_W  latched writeback data.
REQ-017 pmem_rdata  input  LINE_W  memory read data; valid with pmem_resp.
REQ-018 pmem_resp  input  1  memory completion pulse.

Function
REQ-019 FSM states: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
REQ-020 IDLE: no pmem command, no resp; on an edge with a pending request, latch address (and d_wdata plus direction for D) and enter SERVE_I or SERVE_D.
REQ-021 When i_read and (d_read or d_write) are pending together in IDLE, grant per REQ-033/034.
REQ-022 d_read and d_write asserted together: treat as write.
REQ-023 SERVE_x: drive pmem_read or pmem_write continuously from latched values; inputs are not re-sampled.
REQ-024 SERVE_x with pmem_resp=1: capture pmem_rdata into a line buffer (reads only), deassert pmem command next cycle, enter DONE_x.
REQ-025 DONE_x: x_resp=1 for exactly one cycle with x_rdata=line buffer; next state IDLE.
REQ-026 Latency: request seen at edge N gives command at N+1; pmem_resp at cycle K gives x_resp at K+1.
REQ-027 pmem_resp outside SERVE_x is ignored.
REQ-028 The requester deasserts in the cycle after its resp, so IDLE never regrants a completed request.
REQ-029 When neither requester is granted, i_rdata/d_rdata hold the line buffer and both resps are 0.

Reset
REQ-030 rst gives IDLE next cycle: pmem_read=pmem_write=0, i_resp=d_resp=0, address/wdata/line buffer=0, priority pointer=I-cache.
REQ-031 rst during SERVE_x or DONE_x aborts the transaction; no resp is issued; a pmem_resp arriving in the following cycle is ignored.
REQ-032 rst dominates all other inputs in the same cycle.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: on conflict, grant the requester not served last; pointer updates on entry to DONE_x; first conflict after reset goes to I-cache.
REQ-034 Macro undefined: fixed priority, D-cache always wins a conflict; no pointer state.

Verification
REQ-035 i_read=1, i_address=0x0000_1000, memory responds 3 cycles after command with 0xA5 pattern -> pmem_read=1 at 0x1000 for 3 cycles, i_resp=1 for one cycle with i_rdata=pattern, then IDLE.
REQ-036 d_write=1, d_address=0x0000_2040, d_wdata=0x1234... -> pmem_write=1 with the same address/data, d_resp pulses once, i_resp stays 0.
REQ-037 i_read and d_read together at 0x100/0x200, both held -> fixed mode: D served, then I; round-robin: I, then D; each resp pulses exactly once.
REQ-038 Round-robin, both requesters re-requesting continuously for 4 transactions -> grants alternate I,D,I,D.
REQ-039 rst=1 for one cycle in mid-SERVE_D, then late pmem_resp=1 -> no d_resp, pmem_read=0 after the rst edge, FSM in IDLE.
REQ-040 Stray pmem_resp=1 while IDLE with no requests -> no resp, no state change.
